// File: rtl/lc3b_types.sv
// Shared LC-3b types: word, write mask, memory
// responder FSM state and latency limit.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam int LC3B_MEM_MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } lc3b_memresp_state;

endpackage

// File: rtl/lc3b_mem_array.sv
// Word-organised storage, byte-lane write, registered read.
// Ports: clk; addr word index; we lane enables [0]=lo [1]=hi;
// wdata; re loads rdata from mem[addr]; rdata. No reset.
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  lc3b_mem_wmask        we,
  input  lc3b_word             wdata,
  input  logic                 re,
  output lc3b_word             rdata
);

  lc3b_word mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    if (re)    rdata           <= mem[addr];
  end

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory responder: fixed-latency read/write service.
// Ports: clk; reset (async, high); mem_read; mem_write;
// mem_byte_enable; mem_address (byte); mem_wdata;
// mem_resp (1-cycle pulse); mem_rdata (held read data).
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  output logic          mem_resp,
  output lc3b_word      mem_rdata
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  lc3b_memresp_state state, state_n;

  logic [3:0]           cnt, cnt_n;
  logic                 accept, go_resp;
  logic                 cap_wr;
  logic [ADDR_BITS-1:0] cap_idx;
  lc3b_word             cap_wdata;
  lc3b_mem_wmask        cap_be;
  logic                 rd_ok;

  logic                 cur_wr;
  logic [ADDR_BITS-1:0] cur_idx;
  lc3b_word             cur_wdata;
  lc3b_mem_wmask        cur_be;
  lc3b_mem_wmask        arr_we;
  logic                 arr_re;
  lc3b_word             arr_rdata;
  logic                 unused_addr;

  assign unused_addr = ^mem_address;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    go_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_read | mem_write) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_n = RESP;
            go_resp = 1'b1;
          end else begin
            state_n = BUSY;
            cnt_n   = LAT_M1;
          end
        end
      end
      BUSY: begin
        if (cnt <= 4'd1) begin
          state_n = RESP;
          go_resp = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // With LATENCY=1 the commit edge is also the
  // accept edge, so the live request is used.
  always_comb begin
    if (state == IDLE) begin
      cur_wr    = mem_write;
      cur_idx   = mem_address[ADDR_BITS:1];
      cur_wdata = mem_wdata;
      cur_be    = mem_byte_enable;
    end else begin
      cur_wr    = cap_wr;
      cur_idx   = cap_idx;
      cur_wdata = cap_wdata;
      cur_be    = cap_be;
    end
  end

  // Gate with reset so nothing commits while held.
  assign arr_we = (go_resp && cur_wr && !reset)
                ? cur_be : 2'b00;
  assign arr_re = go_resp && !cur_wr && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_wr    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      rd_ok     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        cap_wr    <= mem_write;
        cap_idx   <= mem_address[ADDR_BITS:1];
        cap_wdata <= mem_wdata;
        cap_be    <= mem_byte_enable;
      end
      if (arr_re) rd_ok <= 1'b1;
    end
  end

  lc3b_mem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk  (clk),
    .addr (cur_idx),
    .we   (arr_we),
    .wdata(cur_wdata),
    .re   (arr_re),
    .rdata(arr_rdata)
  );

  // The array read register has no reset; rd_ok
  // presents zero until the first read after reset.
  assign mem_resp  = (state == RESP);
  assign mem_rdata = rd_ok ? arr_rdata : 16'h0000;

endmodule

// File: doc/lc3b_mem_responder.md
# lc3b_mem_responder

Memory-side responder for the LC-3b CPU memory interface: it services the `mem_read`/`mem_write` requests issued by the CPU top level with a fixed, parameterised latency and a one-cycle `mem_resp` pulse. It holds a word-organised storage array with byte-lane writes. It sits opposite the CPU in simulation and FPGA bring-up, in place of the testbench magic memory.

## Interface
Parameters:
- `ADDR_BITS`, default 8: number of word-index bits; storage depth is 2^ADDR_BITS 16-bit words.
- `LATENCY`, default 3: cycles from request acceptance to `mem_resp`; legal range 1..15.

Ports:
- `clk`  in  1: the block's single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `mem_read`  in  1: read request, held by the initiator until `mem_resp`.
- `mem_write`  in  1: write request, held by the initiator until `mem_resp`.
- `mem_byte_enable`  in  2 (`lc3b_mem_wmask`): write lane enables; bit0 selects [7:0], bit1 selects [15:8].
- `mem_address`  in  16 (`lc3b_word`): byte address.
- `mem_wdata`  in  16 (`lc3b_word`): write data.
- `mem_resp`  out  1: one-cycle completion pulse.
- `mem_rdata`  out  16 (`lc3b_word`): registered read data.

## Operation
- FSM states are IDLE, BUSY and RESP.
- IDLE: if `mem_read | mem_write`, accept the request. Capture the op, the word index `mem_address[ADDR_BITS:1]`, `mem_wdata` and `mem_byte_enable`.
  - If LATENCY=1, go to RESP.
  - Otherwise load the counter with LATENCY-1 and go to BUSY.
- BUSY: decrement the counter. When it reaches 1, go to RESP.
- RESP: `mem_resp`=1 for exactly this cycle, then return to IDLE.
- Transition into RESP (on that clock edge):
  - Write: update only the enabled byte lanes of the captured word. A mask of 2'b00 writes nothing but still responds.
  - Read: load `mem_rdata` from the captured word.
- `mem_rdata` holds its value at all other times; writes do not change it.
- Address rules:
  - `mem_address[0]` is ignored.
  - Bits above ADDR_BITS are ignored, so the address aliases and wraps modulo 2^(ADDR_BITS+1) bytes.
- If both `mem_read` and `mem_write` are asserted, the write takes priority and `mem_rdata` is unchanged.
- Requests in BUSY or RESP are not sampled. A request still asserted in the cycle after RESP (the IDLE cycle) is accepted as a new transaction.
- If the initiator drops its request mid-transaction, the captured transaction still completes: the write is committed and `mem_resp` still pulses.
- Reset:
  - Forces IDLE, counter 0, `mem_resp`=0 and `mem_rdata`=16'h0000.
  - A pending transaction is discarded and no write is committed.
  - The storage array is not cleared; its contents are undefined until written.

## Timing
- Request first visible in IDLE in cycle t gives `mem_resp` high in cycle t+LATENCY.
- Read data is valid in cycle t+LATENCY and held afterwards.
- A write is visible to any read accepted after its `mem_resp`.
- Back-to-back throughput is one transaction per LATENCY+1 cycles (one IDLE cycle between transactions).
- Reset output values: `mem_resp`=0, `mem_rdata`=0.

## Structure
- The shared package `lc3b_types` already holds `lc3b_word` and `lc3b_mem_wmask`.
- Add to that package:
  - the state enum `lc3b_memresp_state` (IDLE, BUSY, RESP);
  - the constant `LC3B_MEM_MAX_LATENCY` = 15.
- The counter width is 4 bits.
- Sub-module `lc3b_mem_array`: a 2^ADDR_BITS × 16 synchronous array with a 2-bit byte write enable and a registered read port. It has no reset.
- The FSM, counter and capture registers live in the top module.

## Test plan
- LATENCY=3: write 16'hBEEF to address 16'h0010 with mask 2'b11, then read 16'h0010 → `mem_resp` arrives exactly 3 cycles after each request and the read returns 16'hBEEF.
- Byte lanes: write 16'h1234 (mask 11), then 16'hAB00 (mask 10), then 16'h00CD (mask 01) to address 16'h0020 → read returns 16'hABCD.
- Aliasing with ADDR_BITS=8: write 16'h5555 to address 16'h0202, read 16'h0002 and 16'h0003 → both return 16'h5555.
- Request held after RESP: `mem_read` stays high for two reads → exactly one idle cycle between the `mem_resp` pulses, and each pulse is one cycle wide.
- Mid-operation events:
  - Drop `mem_write` after one cycle → `mem_resp` still pulses and the data is written.
  - Assert `reset` during BUSY of a write of 16'hFFFF over 16'h0000 → `mem_resp`=0 and `mem_rdata`=0 immediately; a later read returns 16'h0000.
- LATENCY=1 and read+write asserted together → `mem_resp` the next cycle, the write is committed and `mem_rdata` is unchanged.
